// File: rtl/carry_lookahead_adder_64b_pkg.sv
// cla_pkg: shared widths and types for the 64-bit carry-lookahead adder.
//   CLA_WIDTH  - operand/sum width
//   CLA_GROUP  - lookahead fan-in at every tree level
//   CLA_BLOCKS - number of 16-bit blocks under the top-level lookahead
//   word_t     - 64-bit operand word
//   gp_t       - generate/propagate pair
package cla_pkg;
   localparam int CLA_WIDTH  = 64;
   localparam int CLA_GROUP  = 4;
   localparam int CLA_BLOCKS = 4;

   typedef logic [CLA_WIDTH-1:0] word_t;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;
endpackage

// File: rtl/carry_lookahead_adder_64b_if.sv
// Operand/result bundle for carry_lookahead_adder_64b.
//   a, b, carry_in        - operands driven by the master
//   sum, carry_out, done  - registered results driven by the slave (the adder)
interface carry_lookahead_adder_64b_if;
   import cla_pkg::*;

   word_t a;
   word_t b;
   logic  carry_in;
   word_t sum;
   logic  carry_out;
   logic  done;

   modport master (output a, b, carry_in, input  sum, carry_out, done);
   modport slave  (input  a, b, carry_in, output sum, carry_out, done);
endinterface

// File: rtl/carry_lookahead_adder_64b_cla_lookahead_unit.sv
// cla_lookahead_unit: one 4-wide lookahead node, reused at every tree level.
//   gp_in  - four generate/propagate pairs, index 0 is least significant
//   cin    - carry into position 0
//   c_out  - carries into positions 1..3 (two-level logic, no ripple)
//   gp_out - group generate/propagate for the next level up
module cla_lookahead_unit
   import cla_pkg::*;
(
   input  gp_t [3:0] gp_in,
   input  logic      cin,
   output logic [3:1] c_out,
   output gp_t       gp_out
);
   logic [3:0] g, p;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         g[i] = gp_in[i].g;
         p[i] = gp_in[i].p;
      end
   end

   assign c_out[1] = g[0] | (p[0] & cin);
   assign c_out[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c_out[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & cin);

   assign gp_out.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
   assign gp_out.p = &p;
endmodule

// File: rtl/carry_lookahead_adder_64b.sv
// carry_lookahead_adder_64b: registered 64-bit adder, sum = a + b + carry_in.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - slave side: a, b, carry_in in; sum, carry_out, done out
// Operands are registered, added by a three-level lookahead tree
// (4-bit groups, 16-bit blocks, 64-bit top), and the result is registered.
// done is high only when the registered result comes from operands that
// were identical on two consecutive edges.
module carry_lookahead_adder_64b
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int GROUP = CLA_GROUP
)(
   input  logic clk,
   input  logic reset,
   carry_lookahead_adder_64b_if.slave bus
);
   localparam int NGRP = WIDTH / GROUP;
   localparam int NBLK = NGRP / GROUP;

   // operand stage
   logic [WIDTH-1:0] a_q, b_q;
   logic             cin_q, vld_q, chg_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         cin_q <= 1'b0;
         vld_q <= 1'b0;
         chg_q <= 1'b1;
      end else begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         cin_q <= bus.carry_in;
         vld_q <= 1'b1;
         // the first edge after reset counts as a change
         chg_q <= ~vld_q | ({bus.a, bus.b, bus.carry_in} != {a_q, b_q, cin_q});
      end
   end

   // lookahead tree
   gp_t [WIDTH-1:0]             bit_gp;
   logic [WIDTH:0]              c;
   gp_t [NGRP-1:0]              grp_gp;
   logic [NGRP-1:0]             grp_cin;
   gp_t [NBLK-1:0]              blk_gp;
   logic [NBLK-1:0]             blk_cin;
   logic [NBLK-1:0][GROUP-1:1]  blk_c;
   logic [GROUP-1:1]            top_c;
   gp_t                         top_gp;
   logic [WIDTH-1:0]            s_comb;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bit_gp[i].g = a_q[i] & b_q[i];
      assign bit_gp[i].p = a_q[i] ^ b_q[i];
      assign s_comb[i]   = bit_gp[i].p ^ c[i];
   end

   for (genvar j = 0; j < NGRP; j++) begin : g_grp
      assign c[GROUP*j] = grp_cin[j];
      cla_lookahead_unit u_grp (
         .gp_in  (bit_gp[GROUP*j +: GROUP]),
         .cin    (grp_cin[j]),
         .c_out  (c[GROUP*j+1 +: GROUP-1]),
         .gp_out (grp_gp[j])
      );
   end

   for (genvar k = 0; k < NBLK; k++) begin : g_blk
      cla_lookahead_unit u_blk (
         .gp_in  (grp_gp[GROUP*k +: GROUP]),
         .cin    (blk_cin[k]),
         .c_out  (blk_c[k]),
         .gp_out (blk_gp[k])
      );
      assign grp_cin[GROUP*k] = blk_cin[k];
      for (genvar m = 1; m < GROUP; m++) begin : g_gc
         assign grp_cin[GROUP*k+m] = blk_c[k][m];
      end
   end

   cla_lookahead_unit u_top (
      .gp_in  (blk_gp),
      .cin    (cin_q),
      .c_out  (top_c),
      .gp_out (top_gp)
   );

   assign blk_cin[0] = cin_q;
   for (genvar m = 1; m < NBLK; m++) begin : g_bc
      assign blk_cin[m] = top_c[m];
   end

   // carry out of bit 63 comes straight from the top-level group terms
   assign c[WIDTH] = top_gp.g | (top_gp.p & cin_q);

   // result stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.sum       <= '0;
         bus.carry_out <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.sum       <= s_comb;
         bus.carry_out <= c[WIDTH];
         bus.done      <= vld_q & ~chg_q;
      end
   end
endmodule

// File: tb/tb_carry_lookahead_adder_64b.sv
// Directed bench for carry_lookahead_adder_64b: hand-computed vectors,
// done timing after reset and after operand changes, glitch immunity and
// asynchronous reset in the middle of a cycle.
module tb_carry_lookahead_adder_64b;
   import cla_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   carry_lookahead_adder_64b_if bus ();

   carry_lookahead_adder_64b dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input word_t a, input word_t b, input logic cin);
      bus.a        = a;
      bus.b        = b;
      bus.carry_in = cin;
   endtask

   // change operands while done=1, then follow the edge-by-edge response
   task automatic run_vec(input string tag, input word_t a, input word_t b,
                          input logic cin, input word_t es, input logic ec);
      drive(a, b, cin);
      tick();
      chk({tag, "_e1_done"}, 64'(bus.done), 64'd1);
      tick();
      chk({tag, "_e2_sum"},  bus.sum, es);
      chk({tag, "_e2_cout"}, 64'(bus.carry_out), 64'(ec));
      chk({tag, "_e2_done"}, 64'(bus.done), 64'd0);
      tick();
      chk({tag, "_e3_done"}, 64'(bus.done), 64'd1);
      chk({tag, "_e3_sum"},  bus.sum, es);
   endtask

   initial begin
      reset = 1'b1;
      drive(64'd0, 64'd0, 1'b0);
      #2;
      chk("rst_sum",  bus.sum, 64'd0);
      chk("rst_cout", 64'(bus.carry_out), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);

      @(negedge clk);
      reset = 1'b0;
      drive(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
      tick();
      chk("first_e1_done", 64'(bus.done), 64'd0);
      tick();
      chk("first_e2_sum",  bus.sum, 64'h2222_2222_2222_2211);
      chk("first_e2_cout", 64'(bus.carry_out), 64'd0);
      chk("first_e2_done", 64'(bus.done), 64'd0);
      tick();
      chk("first_e3_done", 64'(bus.done), 64'd1);
      tick();
      chk("first_e4_done", 64'(bus.done), 64'd1);

      run_vec("wrap1",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
              64'h0000_0000_0000_0000, 1'b1);
      run_vec("ones",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      run_vec("fullp",  64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1,
              64'h0000_0000_0000_0000, 1'b1);
      run_vec("cinonly", 64'd0, 64'd0, 1'b1, 64'd1, 1'b0);
      run_vec("blk32",  64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
              64'h0000_0001_0000_0000, 1'b0);
      run_vec("blk16",  64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
              64'h0000_0000_0001_0000, 1'b0);

      // glitch between edges, restored before the next edge
      bus.a = 64'h1111_1111_1111_1111;
      #3;
      bus.a = 64'h0000_0000_0000_FFFF;
      tick();
      chk("glitch_done", 64'(bus.done), 64'd1);
      chk("glitch_sum",  bus.sum, 64'h0000_0000_0001_0000);

      // asynchronous reset between edges while done=1 and sum nonzero
      #3;
      reset = 1'b1;
      #1;
      chk("midrst_sum",  bus.sum, 64'd0);
      chk("midrst_cout", 64'(bus.carry_out), 64'd0);
      chk("midrst_done", 64'(bus.done), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
      tick();
      chk("rel_e1_done", 64'(bus.done), 64'd0);
      chk("rel_e1_sum",  bus.sum, 64'd0);
      tick();
      chk("rel_e2_done", 64'(bus.done), 64'd0);
      chk("rel_e2_sum",  bus.sum, 64'h2222_2222_2222_2211);
      tick();
      chk("rel_e3_done", 64'(bus.done), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/carry_lookahead_adder_64b.md
Name: carry_lookahead_adder_64b

Overview:
- Registered 64-bit adder: sum = a + b + carry_in, with carry_out and a done flag.
- Built from a three-level carry-lookahead tree: 4-bit groups, 16-bit blocks, then a 64-bit top level.
- Two register stages: an operand stage, then a result stage.
- Used as the wide-add datapath element of the CPU.
- done tells the consumer that sum/carry_out belong to operands that were held stable.

Parameters:
- WIDTH, 64, operand/sum width. Only 64 is required to work; it is kept as a parameter for package consistency.
- GROUP, 4, lookahead fan-in at every tree level.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- a  input  64  operand A
- b  input  64  operand B
- carry_in  input  1  carry into bit 0
- sum  output  64  registered (a + b + carry_in) mod 2^64
- carry_out  output  1  registered carry out of bit 63
- done  output  1  registered; 1 = sum/carry_out are valid for stable operands

Behaviour:
- Reset (asserted asynchronously, held while reset=1) clears:
  - a_q, b_q, cin_q, vld_q to 0;
  - chg_q to 1;
  - sum, carry_out, done to 0.
- Operand stage, every posedge when reset=0:
  - a_q<=a, b_q<=b, cin_q<=carry_in, vld_q<=1;
  - chg_q <= ~vld_q | ({a,b,carry_in} != {a_q,b_q,cin_q}).
- Combinational CLA on {a_q,b_q,cin_q}:
  - per bit: g=a&b, p=a^b;
  - 4-bit group carries from g/p/cin; each group produces G,P;
  - a 16-bit block lookahead over 4 groups produces block G,P;
  - the top-level lookahead over 4 blocks produces the block carry-ins;
  - s[i] = p[i] ^ c[i]; carry_out = c[64].
- No ripple chain longer than 4 bits is permitted.
- Result stage, every posedge when reset=0:
  - sum <= CLA sum; carry_out <= CLA carry;
  - done <= vld_q & ~chg_q.
- Latency: result of operands sampled at edge N appears after edge N+1.
- done rule:
  - done rises after edge N+2 if the operands were unchanged at edges N and N+1.
  - Any operand change is sampled at an edge; done is 0 after the following edge.
  - done stays 1 for as long as the inputs stay constant.
- First edges after reset release:
  - edge 1 sets vld_q and forces chg_q=1;
  - edge 2 gives done=0 with the first valid sum;
  - edge 3 gives done=1 if the inputs are stable.
- Overflow wraps mod 2^64; carry_out is the 65th bit. The design has no signed overflow flag.
- Reset mid-operation: outputs go to 0 immediately and in-flight operands are discarded. The first-edge sequence above restarts from zero.
- Inputs are sampled only at clock edges; glitches between edges have no effect.

Decomposition:
- Package cla_pkg holds:
  - CLA_WIDTH=64, CLA_GROUP=4, CLA_BLOCKS=4;
  - typedef word_t (logic [63:0]);
  - typedef gp_t (struct: g, p).
- One sub-module, cla_lookahead_unit, instantiated 21 times (16 group level + 4 block level + 1 top):
  - inputs: 4 g/p pairs and cin;
  - outputs: carries c1..c3, group G, group P.
- Bit g/p generation, sum XOR and both register stages stay in the top module.

Test Plan:
- 1234_5678_9ABC_DEF0 + 0FED_CBA9_8765_4321, cin=0 -> sum=2222_2222_2222_2211, carry_out=0, done=1 after 3 stable edges.
- FFFF_FFFF_FFFF_FFFF + 0000_0000_0000_0001, cin=0 -> sum=0, carry_out=1.
- FFFF_FFFF_FFFF_FFFF + FFFF_FFFF_FFFF_FFFF, cin=1 -> sum=FFFF_FFFF_FFFF_FFFF, carry_out=1.
- AAAA_AAAA_AAAA_AAAA + 5555_5555_5555_5555, cin=1 (full propagate through all levels) -> sum=0, carry_out=1.
- Operand change while done=1:
  - done=0 after the second edge following the change;
  - sum updates at that same edge;
  - done returns to 1 one edge later.
- Assert reset while done=1 with nonzero sum, between clock edges -> sum, carry_out, done = 0 immediately.
  - After release with stable inputs: done=0, 0, then 1 on edges 1–3.
